// File: rtl/iccm_arb_pkg.sv
// Shared types and constants for the ICCM port arbiter: FSM state encoding,
// SRAM geometry and the SRAM idle (deselected) control levels.
package iccm_arb_pkg;

  localparam int ICCM_AW = 10;
  localparam int ICCM_DW = 32;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RD_PEND = 2'd1,
    RD_HOLD = 2'd2
  } arb_state_e;

  localparam logic SRAM_DESELECT_CSB = 1'b1;
  localparam logic SRAM_DESELECT_WEB = 1'b1;

endpackage

// File: rtl/iccm_port_arbiter_if.sv
// Requester A/B, SRAM macro and lock signals of the ICCM arbiter. The perf
// counter signals exist only when ICCM_ARB_PERF_EN is defined.
interface iccm_port_arbiter_if import iccm_arb_pkg::*; #(
  parameter int AW = ICCM_AW,
  parameter int DW = ICCM_DW
);
  // Handshakes: a requester holds req/addr/data stable until the grant it sees
  // combinationally in the same cycle; a B read response is offered with
  // b_rvalid_o and retires on the first cycle b_rready_i is also high.
  logic          lock_i;
  logic          a_req_i;
  logic          a_gnt_o;
  logic [AW-1:0] a_addr_i;
  logic [DW-1:0] a_wdata_i;
  logic [3:0]    a_wmask_i;
  logic          b_req_i;
  logic          b_gnt_o;
  logic          b_we_i;
  logic [AW-1:0] b_addr_i;
  logic [DW-1:0] b_wdata_i;
  logic [3:0]    b_wmask_i;
  logic          b_rvalid_o;
  logic [DW-1:0] b_rdata_o;
  logic          b_rready_i;
  logic          sram_csb_o;
  logic          sram_web_o;
  logic [3:0]    sram_wmask_o;
  logic [AW-1:0] sram_addr_o;
  logic [DW-1:0] sram_wdata_o;
  logic [DW-1:0] sram_rdata_i;
`ifdef ICCM_ARB_PERF_EN
  logic          perf_clr_i;
  logic [31:0]   perf_conflict_o;
`endif

  modport slave (
    input  lock_i, a_req_i, a_addr_i, a_wdata_i, a_wmask_i,
    input  b_req_i, b_we_i, b_addr_i, b_wdata_i, b_wmask_i, b_rready_i,
    input  sram_rdata_i,
`ifdef ICCM_ARB_PERF_EN
    input  perf_clr_i,
    output perf_conflict_o,
`endif
    output a_gnt_o, b_gnt_o, b_rvalid_o, b_rdata_o,
    output sram_csb_o, sram_web_o, sram_wmask_o, sram_addr_o, sram_wdata_o
  );

  modport master (
    output lock_i, a_req_i, a_addr_i, a_wdata_i, a_wmask_i,
    output b_req_i, b_we_i, b_addr_i, b_wdata_i, b_wmask_i, b_rready_i,
    output sram_rdata_i,
`ifdef ICCM_ARB_PERF_EN
    output perf_clr_i,
    input  perf_conflict_o,
`endif
    input  a_gnt_o, b_gnt_o, b_rvalid_o, b_rdata_o,
    input  sram_csb_o, sram_web_o, sram_wmask_o, sram_addr_o, sram_wdata_o
  );

endinterface

// File: rtl/iccm_arb_rsp_buf.sv
// B read response buffer: tracks rvalid and keeps a copy of the SRAM read data
// once B back-pressures, so later SRAM activity cannot disturb the response.
module iccm_arb_rsp_buf import iccm_arb_pkg::*; #(
  parameter int DW = ICCM_DW
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          launch,
  input  logic          capture,
  input  logic          rsp_release,
  input  logic [DW-1:0] sram_rdata,
  output logic          rvalid,
  output logic [DW-1:0] rdata
);

  logic          rvalid_q;
  logic          sel_hold_q;
  logic [DW-1:0] hold_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_q   <= 1'b0;
      sel_hold_q <= 1'b0;
      hold_q     <= '0;
    end else begin
      if (launch)           rvalid_q <= 1'b1;
      else if (rsp_release) rvalid_q <= 1'b0;

      if (launch)           sel_hold_q <= 1'b0;
      else if (capture)     sel_hold_q <= 1'b1;
      else if (rsp_release) sel_hold_q <= 1'b0;

      if (capture) hold_q <= sram_rdata;
    end
  end

  // Read data is forced to zero whenever no response is being offered.
  assign rvalid = rvalid_q;
  assign rdata  = !rvalid_q ? '0 : (sel_hold_q ? hold_q : sram_rdata);

endmodule

// File: rtl/iccm_port_arbiter.sv
// Two-port arbiter for the single-port ICCM SRAM: A (loader) has fixed priority
// bounded by MAX_A_BURST, B (fetch) gets 1-cycle reads. Optional ICCM_ARB_PERF_EN.
module iccm_port_arbiter import iccm_arb_pkg::*; #(
  parameter int AW          = ICCM_AW,
  parameter int DW          = ICCM_DW,
  parameter int MAX_A_BURST = 8
) (
  input  logic               clk_i,
  input  logic               rst_i,
  iccm_port_arbiter_if.slave bus,
  output arb_state_e         dbg_state_o
);

  localparam int SW = $clog2(MAX_A_BURST + 1);
  localparam logic [SW-1:0] STARVE_MAX = SW'(MAX_A_BURST);

  arb_state_e    state;
  logic [SW-1:0] starve_cnt;
  logic          b_eligible;
  logic          b_cand;
  logic          b_win;
  logic          a_win;
  logic          rd_launch;
  logic          rsp_capture;
  logic          rsp_release;
  logic          rvalid;
  logic [DW-1:0] rdata;

  // B may only be granted when any outstanding response retires this cycle.
  always_comb begin
    b_eligible = !bus.lock_i && ((state == IDLE) || bus.b_rready_i);
    b_cand     = bus.b_req_i && b_eligible;
    b_win      = !rst_i && b_cand && (!bus.a_req_i || (starve_cnt == STARVE_MAX));
    a_win      = !rst_i && bus.a_req_i && !b_win;
  end

  assign rd_launch   = b_win && !bus.b_we_i;
  assign rsp_release = rvalid && bus.b_rready_i;
  assign rsp_capture = (state == RD_PEND) && !bus.b_rready_i;

  assign bus.a_gnt_o = a_win;
  assign bus.b_gnt_o = b_win;

  always_comb begin
    bus.sram_csb_o   = SRAM_DESELECT_CSB;
    bus.sram_web_o   = SRAM_DESELECT_WEB;
    bus.sram_addr_o  = {AW{1'b0}};
    bus.sram_wdata_o = {DW{1'b0}};
    bus.sram_wmask_o = 4'h0;
    if (a_win) begin
      bus.sram_csb_o   = 1'b0;
      bus.sram_web_o   = 1'b0;
      bus.sram_addr_o  = bus.a_addr_i;
      bus.sram_wdata_o = bus.a_wdata_i;
      bus.sram_wmask_o = bus.a_wmask_i;
    end else if (b_win) begin
      bus.sram_csb_o  = 1'b0;
      bus.sram_web_o  = !bus.b_we_i;
      bus.sram_addr_o = bus.b_addr_i;
      if (bus.b_we_i) begin
        bus.sram_wdata_o = bus.b_wdata_i;
        bus.sram_wmask_o = bus.b_wmask_i;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state      <= IDLE;
      starve_cnt <= '0;
    end else begin
      case (state)
        IDLE:    if (rd_launch) state <= RD_PEND;
        RD_PEND: begin
          if (!bus.b_rready_i) state <= RD_HOLD;
          else if (!rd_launch) state <= IDLE;
        end
        RD_HOLD: if (bus.b_rready_i) state <= rd_launch ? RD_PEND : IDLE;
        default: state <= IDLE;
      endcase

      // Counts only A wins taken while B was waiting and could have gone.
      if (b_win || !b_cand) starve_cnt <= '0;
      else if (a_win && (starve_cnt != STARVE_MAX)) starve_cnt <= starve_cnt + 1'b1;
    end
  end

  iccm_arb_rsp_buf #(.DW(DW)) u_rsp_buf (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .launch      (rd_launch),
    .capture     (rsp_capture),
    .rsp_release (rsp_release),
    .sram_rdata  (bus.sram_rdata_i),
    .rvalid      (rvalid),
    .rdata       (rdata)
  );

  assign bus.b_rvalid_o = rvalid;
  assign bus.b_rdata_o  = rdata;
  assign dbg_state_o    = state;

`ifdef ICCM_ARB_PERF_EN
  logic [31:0] perf_q;

  always_ff @(posedge clk_i) begin
    if (rst_i || bus.perf_clr_i) begin
      perf_q <= 32'h0;
    end else if (bus.a_req_i && bus.b_req_i && (a_win ^ b_win) && (perf_q != 32'hFFFF_FFFF)) begin
      perf_q <= perf_q + 32'h1;
    end
  end

  assign bus.perf_conflict_o = perf_q;
`endif

endmodule

// File: tb/tb_iccm_port_arbiter.sv
// Directed bench for iccm_port_arbiter: a vector table plus hand-written
// sequences for starvation, held responses, lock, reset and the perf counter.
module tb_iccm_port_arbiter;
  import iccm_arb_pkg::*;

  // clock / reset
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  iccm_port_arbiter_if #(.AW(10), .DW(32)) bus ();
  arb_state_e dbg_state;

  iccm_port_arbiter #(.AW(10), .DW(32), .MAX_A_BURST(8)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .bus         (bus),
    .dbg_state_o (dbg_state)
  );

  int total = 0;
  int bad   = 0;
  logic [1:0] exp_q[$];

  typedef struct {
    logic        lk, a, b, we, rdy;
    logic [9:0]  aa, ba;
    logic [31:0] rd;
    logic        ea, eb, ev;
    logic [31:0] erd;
    logic        ecsb, eweb;
    logic [9:0]  eaddr;
  } vec_t;
  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // driver
  task automatic drive(input logic lk, input logic a, input logic [9:0] aa,
                       input logic b, input logic we, input logic [9:0] ba,
                       input logic rdy, input logic [31:0] rd);
    bus.lock_i       = lk;
    bus.a_req_i      = a;
    bus.a_addr_i     = aa;
    bus.a_wdata_i    = 32'hA5A5_0000 | {22'h0, aa};
    bus.a_wmask_i    = 4'hF;
    bus.b_req_i      = b;
    bus.b_we_i       = we;
    bus.b_addr_i     = ba;
    bus.b_wdata_i    = 32'hB0B0_0000 | {22'h0, ba};
    bus.b_wmask_i    = 4'h3;
    bus.b_rready_i   = rdy;
    bus.sram_rdata_i = rd;
  endtask

  task automatic chk(input string tag, input logic ea, input logic eb, input logic ev,
                     input logic [31:0] erd);
    check({tag, " a_gnt"}, {31'h0, bus.a_gnt_o}, {31'h0, ea});
    check({tag, " b_gnt"}, {31'h0, bus.b_gnt_o}, {31'h0, eb});
    check({tag, " rvalid"}, {31'h0, bus.b_rvalid_o}, {31'h0, ev});
    check({tag, " rdata"}, bus.b_rdata_o, erd);
  endtask

  task automatic add(input logic lk, a, b, we, rdy, input logic [9:0] aa, ba,
                     input logic [31:0] rd, input logic ea, eb, ev, input logic [31:0] erd,
                     input logic ecsb, eweb, input logic [9:0] eaddr);
    vec_t v;
    v.lk = lk; v.a = a; v.b = b; v.we = we; v.rdy = rdy; v.aa = aa; v.ba = ba; v.rd = rd;
    v.ea = ea; v.eb = eb; v.ev = ev; v.erd = erd; v.ecsb = ecsb; v.eweb = eweb; v.eaddr = eaddr;
    vecs.push_back(v);
  endtask

  initial begin
    int last_b;
    logic [1:0] e;
    logic [31:0] ewd;
    logic [3:0]  ewm;
    vec_t v;

    //   lk a  b  we rdy aa      ba      rd             | ea eb ev erd           csb web addr
    add(0, 0, 0, 0, 1, 10'h000, 10'h000, 32'h0,         0, 0, 0, 32'h0,         1, 1, 10'h000);
    add(0, 0, 1, 0, 1, 10'h000, 10'h010, 32'h0,         0, 1, 0, 32'h0,         0, 1, 10'h010);
    add(0, 0, 0, 0, 1, 10'h000, 10'h000, 32'hDEADBEEF,  0, 0, 1, 32'hDEADBEEF,  1, 1, 10'h000);
    add(0, 1, 0, 0, 1, 10'h020, 10'h000, 32'h0,         1, 0, 0, 32'h0,         0, 0, 10'h020);
    add(0, 1, 1, 0, 1, 10'h030, 10'h040, 32'h0,         1, 0, 0, 32'h0,         0, 0, 10'h030);
    add(0, 0, 1, 0, 1, 10'h000, 10'h040, 32'h0,         0, 1, 0, 32'h0,         0, 1, 10'h040);
    add(0, 1, 0, 0, 0, 10'h050, 10'h000, 32'h11111111,  1, 0, 1, 32'h11111111,  0, 0, 10'h050);
    add(0, 1, 1, 0, 0, 10'h070, 10'h060, 32'h22222222,  1, 0, 1, 32'h11111111,  0, 0, 10'h070);
    add(0, 0, 1, 0, 1, 10'h000, 10'h060, 32'h33333333,  0, 1, 1, 32'h11111111,  0, 1, 10'h060);
    add(0, 0, 0, 0, 1, 10'h000, 10'h000, 32'h44444444,  0, 0, 1, 32'h44444444,  1, 1, 10'h000);
    add(1, 1, 1, 1, 1, 10'h080, 10'h090, 32'h0,         1, 0, 0, 32'h0,         0, 0, 10'h080);
    add(1, 0, 1, 1, 1, 10'h000, 10'h090, 32'h0,         0, 0, 0, 32'h0,         1, 1, 10'h000);
    add(0, 0, 1, 1, 1, 10'h000, 10'h090, 32'h0,         0, 1, 0, 32'h0,         0, 0, 10'h090);
    add(0, 0, 0, 0, 1, 10'h000, 10'h000, 32'h0,         0, 0, 0, 32'h0,         1, 1, 10'h000);
    add(0, 1, 1, 1, 1, 10'h0AA, 10'h0AA, 32'h0,         1, 0, 0, 32'h0,         0, 0, 10'h0AA);

    // reset with A requesting: nothing may be granted
    rst = 1'b1;
    drive(0, 1, 10'h3FF, 0, 0, 10'h0, 1, 32'hFFFF_FFFF);
`ifdef ICCM_ARB_PERF_EN
    bus.perf_clr_i = 1'b0;
`endif
    @(negedge clk);
    @(negedge clk); #1;
    chk("reset", 0, 0, 0, 32'h0);
    check("reset csb", {31'h0, bus.sram_csb_o}, 32'h1);
    check("reset web", {31'h0, bus.sram_web_o}, 32'h1);
    check("reset state", {30'h0, dbg_state}, {30'h0, IDLE});
    rst = 1'b0;
    drive(0, 0, 10'h0, 0, 0, 10'h0, 1, 32'h0);

    // vector table
    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      @(negedge clk);
      drive(v.lk, v.a, v.aa, v.b, v.we, v.ba, v.rdy, v.rd);
      #1;
      chk($sformatf("v%0d", i), v.ea, v.eb, v.ev, v.erd);
      check($sformatf("v%0d csb", i), {31'h0, bus.sram_csb_o}, {31'h0, v.ecsb});
      check($sformatf("v%0d web", i), {31'h0, bus.sram_web_o}, {31'h0, v.eweb});
      check($sformatf("v%0d addr", i), {22'h0, bus.sram_addr_o}, {22'h0, v.eaddr});
      if (!(v.eb && !v.we)) begin
        ewd = v.ea ? (32'hA5A5_0000 | {22'h0, v.aa}) :
              v.eb ? (32'hB0B0_0000 | {22'h0, v.ba}) : 32'h0;
        ewm = v.ea ? 4'hF : (v.eb ? 4'h3 : 4'h0);
        check($sformatf("v%0d wdata", i), bus.sram_wdata_o, ewd);
        check($sformatf("v%0d wmask", i), {28'h0, bus.sram_wmask_o}, {28'h0, ewm});
      end
    end

    // starvation: AAAAAAAA B repeating
    @(negedge clk);
    drive(0, 0, 10'h0, 0, 0, 10'h0, 1, 32'h0);
    for (int i = 0; i < 27; i++) exp_q.push_back(((i % 9) == 8) ? 2'b01 : 2'b10);
    last_b = -1;
    for (int i = 0; i < 27; i++) begin
      @(negedge clk);
      drive(0, 1, 10'h200 + 10'(i), 1, 0, 10'h300, 1, 32'h0);
      #1;
      e = exp_q.pop_front();
      check($sformatf("starve c%0d gnt", i), {30'h0, bus.a_gnt_o, bus.b_gnt_o}, {30'h0, e});
      if (bus.b_gnt_o) begin
        check("starve gap", {31'h0, (i - last_b) <= 9}, 32'h1);
        last_b = i;
      end
    end

    // held response: 3 cycles of back-pressure while SRAM data moves
    @(negedge clk); drive(0, 0, 10'h0, 0, 0, 10'h0, 1, 32'h0); #1;
    @(negedge clk); drive(0, 0, 10'h0, 1, 0, 10'h100, 1, 32'h0); #1;
    chk("hold launch", 0, 1, 0, 32'h0);
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(0, 1, 10'h101 + 10'(k), 1, 0, 10'h102, 0, 32'hCAFE_0001 + k);
      #1;
      chk($sformatf("hold k%0d", k), 1, 0, 1, 32'hCAFE_0001);
      check($sformatf("hold k%0d state", k), {30'h0, dbg_state},
            {30'h0, (k == 0) ? RD_PEND : RD_HOLD});
    end
    @(negedge clk); drive(0, 0, 10'h0, 1, 0, 10'h102, 1, 32'hCAFE_0004); #1;
    chk("hold accept", 0, 1, 1, 32'hCAFE_0001);
    @(negedge clk); drive(0, 0, 10'h0, 0, 0, 10'h0, 1, 32'hCAFE_0009); #1;
    chk("hold next rsp", 0, 0, 1, 32'hCAFE_0009);
    @(negedge clk); drive(0, 0, 10'h0, 0, 0, 10'h0, 1, 32'h0); #1;
    chk("hold done", 0, 0, 0, 32'h0);
    check("hold done state", {30'h0, dbg_state}, {30'h0, IDLE});

    // lock: only A is served, B goes as soon as lock falls
    for (int k = 0; k < 3; k++) begin
      @(negedge clk); drive(1, 1, 10'h140, 1, 1, 10'h150, 1, 32'h0); #1;
      chk($sformatf("lock k%0d", k), 1, 0, 0, 32'h0);
    end
    @(negedge clk); drive(0, 0, 10'h0, 1, 1, 10'h150, 1, 32'h0); #1;
    chk("unlock", 0, 1, 0, 32'h0);
    check("unlock web", {31'h0, bus.sram_web_o}, 32'h0);

    // lock rising with a response outstanding
    @(negedge clk); drive(0, 0, 10'h0, 1, 0, 10'h160, 1, 32'h0); #1;
    chk("lockrsp launch", 0, 1, 0, 32'h0);
    @(negedge clk); drive(1, 0, 10'h0, 1, 0, 10'h161, 1, 32'h0BAD_F00D); #1;
    chk("lockrsp rsp", 0, 0, 1, 32'h0BAD_F00D);
    @(negedge clk); drive(1, 0, 10'h0, 1, 0, 10'h161, 1, 32'h0); #1;
    chk("lockrsp after", 0, 0, 0, 32'h0);
    check("lockrsp state", {30'h0, dbg_state}, {30'h0, IDLE});

    // reset while RD_PEND
    @(negedge clk); drive(0, 0, 10'h0, 1, 0, 10'h1F0, 1, 32'h0); #1;
    chk("rstpend launch", 0, 1, 0, 32'h0);
    @(negedge clk); rst = 1'b1; drive(0, 1, 10'h1F1, 0, 0, 10'h0, 0, 32'h1234_5678); #1;
    chk("rstpend rsp", 0, 0, 1, 32'h1234_5678);
    check("rstpend csb", {31'h0, bus.sram_csb_o}, 32'h1);
    @(negedge clk); rst = 1'b0; drive(0, 0, 10'h0, 0, 0, 10'h0, 1, 32'h5555_5555); #1;
    chk("rstpend after", 0, 0, 0, 32'h0);
    check("rstpend after csb", {31'h0, bus.sram_csb_o}, 32'h1);
    check("rstpend state", {30'h0, dbg_state}, {30'h0, IDLE});

`ifdef ICCM_ARB_PERF_EN
    @(negedge clk); bus.perf_clr_i = 1'b1; drive(0, 0, 10'h0, 0, 0, 10'h0, 1, 32'h0);
    @(negedge clk); bus.perf_clr_i = 1'b0; #1;
    check("perf cleared", bus.perf_conflict_o, 32'h0);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge clk);
      drive(1, 1, 10'h1C0, 1, 1, 10'h1C1, 1, 32'h0);
    end
    @(negedge clk); drive(0, 0, 10'h0, 0, 0, 10'h0, 1, 32'h0); #1;
    check("perf five", bus.perf_conflict_o, 32'h5);
    @(negedge clk); bus.perf_clr_i = 1'b1; drive(1, 1, 10'h1C0, 1, 1, 10'h1C1, 1, 32'h0);
    @(negedge clk); bus.perf_clr_i = 1'b0; drive(0, 0, 10'h0, 0, 0, 10'h0, 1, 32'h0); #1;
    check("perf clr", bus.perf_conflict_o, 32'h0);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iccm_port_arbiter.md
Name: iccm_port_arbiter

Overview:
- Shares the single-port 32x1024 instruction SRAM between two requesters.
- Port A is the UART program loader (write-only, burst writes during programming).
- Port B is the TL-UL instruction memory adapter (fetch reads plus occasional writes).
- Sits between both requesters and the SRAM macro. It provides fixed A priority with a starvation limit, 1-cycle read latency, and a held read response when B back-pressures.

Parameters:
- AW, 10, SRAM word-address width (1024 words)
- DW, 32, data width
- MAX_A_BURST, 8, maximum consecutive A grants while B waits eligibly; the next slot then goes to B

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, synchronous, active-high
- lock_i  in  1  programming mode; B is never granted while high
- a_req_i  in  1  A write request
- a_gnt_o  out  1  A granted this cycle
- a_addr_i  in  AW  A word address
- a_wdata_i  in  DW  A write data
- a_wmask_i  in  4  A byte mask
- b_req_i  in  1  B request
- b_gnt_o  out  1  B granted this cycle
- b_we_i  in  1  B write (1) / read (0)
- b_addr_i  in  AW  B word address
- b_wdata_i  in  DW  B write data
- b_wmask_i  in  4  B byte mask
- b_rvalid_o  out  1  B read data valid
- b_rdata_o  out  DW  B read data
- b_rready_i  in  1  B accepts read data
- sram_csb_o  out  1  chip select, active-low
- sram_web_o  out  1  write enable, active-low
- sram_wmask_o  out  4  byte mask
- sram_addr_o  out  AW  address
- sram_wdata_o  out  DW  write data
- sram_rdata_i  in  DW  read data, valid the cycle after a read access

Behaviour:
- Clock and reset are fixed: single clock clk_i; rst_i is synchronous and active-high.
- Grant is combinational in the same cycle as the request. The SRAM is driven in the grant cycle. Requesters hold their request/address/data stable until granted.
- B eligibility: lock_i=0, and no B read response is outstanding that will not retire this cycle.
- Priority: A wins if a_req_i=1, unless starve_cnt==MAX_A_BURST and B is requesting and eligible; in that case B wins.
- starve_cnt:
  - Increments when A is granted while B is requesting and eligible.
  - Clears on any B grant, or on any cycle B is not requesting or not eligible.
  - Saturates at MAX_A_BURST.
- No grant: sram_csb_o=1, sram_web_o=1; addr, wdata and wmask are don't-care but driven 0.
- FSM states:
  - IDLE -> RD_PEND on a B read grant.
  - RD_PEND: b_rvalid_o=1, b_rdata_o=sram_rdata_i.
    - If b_rready_i=1: B is eligible again. A new B read grant stays in RD_PEND; otherwise go to IDLE.
    - If b_rready_i=0: capture sram_rdata_i into the hold register and go to RD_HOLD.
  - RD_HOLD: b_rvalid_o=1, b_rdata_o=hold register. A writes may be granted. On b_rready_i=1, go to IDLE; a B read may be granted in that same cycle and go to RD_PEND.
- B writes never enter RD_PEND. They complete in the grant cycle.
- A write granted in RD_PEND does not corrupt the pending read data.
- A and B to the same address in the same cycle: A wins; B sees the post-write value on a later read.
- Reset values: a_gnt_o=0, b_gnt_o=0, b_rvalid_o=0, b_rdata_o=0, sram_csb_o=1, sram_web_o=1, other SRAM outputs 0, starve_cnt=0, state IDLE.
- Reset mid-read drops the outstanding response; b_rvalid_o=0 the cycle after rst_i is sampled.
- lock_i rising while a response is outstanding: the response still completes; no new B grants are issued.

Optional Feature:
- Macro ICCM_ARB_PERF_EN.
- Defined: adds ports perf_clr_i (in, 1) and perf_conflict_o (out, 32).
  - The counter increments each cycle both requests are present and one is denied.
  - It saturates at 32'hFFFF_FFFF.
  - perf_clr_i zeroes it next cycle, with priority over increment. Reset value 0.
- Undefined: ports and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package iccm_arb_pkg:
  - arb_state_e enum {IDLE, RD_PEND, RD_HOLD}
  - ICCM_AW=10, ICCM_DW=32
  - SRAM_DESELECT constants (csb=1, web=1)
- Sub-module iccm_arb_rsp_buf: response/hold register plus rvalid logic, driven by the FSM's capture and release strobes.

Test Plan:
- B reads addr 0x010 with b_rready=1, SRAM returns 0xDEADBEEF -> b_gnt_o=1 in cycle 0; b_rvalid_o=1 with 0xDEADBEEF in cycle 1.
- A and B both request continuously with MAX_A_BURST=8 -> grant pattern AAAAAAAA B repeating; b_gnt_o never exceeds 9 cycles apart.
- B read with b_rready=0 for 3 cycles while SRAM rdata changes -> b_rdata_o holds the first value; no B grant until accept; A writes are granted meanwhile.
- lock_i=1 with both requesting -> only a_gnt_o pulses; B is granted the cycle after lock_i falls.
- rst_i asserted in RD_PEND -> b_rvalid_o=0, sram_csb_o=1 the next cycle; state IDLE.
- ICCM_ARB_PERF_EN defined, 5 conflict cycles -> perf_conflict_o=5; perf_clr_i pulse -> 0.
